// File: rtl/alu_arbiter.sv
// alu_arbiter: shares a single combinational ALU between two requesters.
// Requests are granted round-robin. Operands and command are registered toward
// the ALU and held for EXEC_CYCLES clocks. The result is then captured and
// returned on the owner's valid/ready response channel.
module alu_arbiter #(
    parameter int unsigned EXEC_CYCLES = 1
) (
    input  logic        clock,
    input  logic        resetn,

    input  logic        req0_valid,
    output logic        req0_ready,
    input  logic [7:0]  req0_a,
    input  logic [7:0]  req0_b,
    input  logic [3:0]  req0_cmd,
    output logic        rsp0_valid,
    input  logic        rsp0_ready,
    output logic [15:0] rsp0_data,

    input  logic        req1_valid,
    output logic        req1_ready,
    input  logic [7:0]  req1_a,
    input  logic [7:0]  req1_b,
    input  logic [3:0]  req1_cmd,
    output logic        rsp1_valid,
    input  logic        rsp1_ready,
    output logic [15:0] rsp1_data,

    output logic [7:0]  alu_a,
    output logic [7:0]  alu_b,
    output logic [3:0]  alu_cmd,
    output logic        alu_oe,
    input  logic [15:0] alu_d,

    output logic        busy
);

    localparam logic [1:0] IDLE = 2'd0;
    localparam logic [1:0] EXEC = 2'd1;
    localparam logic [1:0] RESP = 2'd2;

    localparam logic [3:0] CNT_LOAD = 4'(EXEC_CYCLES - 1);

    logic [1:0] state;
    logic       last_grant;
    logic       owner;
    logic [3:0] cnt;

    logic       grant0;
    logic       grant1;
    logic       accept0;
    logic       accept1;
    logic       owner_rsp_ready;

    // Round-robin grant: a lone requester wins; on a tie the one not served last wins.
    always_comb begin
        grant0 = 1'b0;
        grant1 = 1'b0;
        if (req0_valid && req1_valid) begin
            grant0 = last_grant;
            grant1 = !last_grant;
        end else begin
            grant0 = req0_valid;
            grant1 = req1_valid;
        end
    end

    // Requests are only accepted while idle; at most one ready can be high.
    always_comb begin
        req0_ready      = grant0 && (state == IDLE);
        req1_ready      = grant1 && (state == IDLE);
        accept0         = req0_ready && req0_valid;
        accept1         = req1_ready && req1_valid;
        owner_rsp_ready = owner ? rsp1_ready : rsp0_ready;
        busy            = (state != IDLE);
    end

    // Control FSM: accept, hold ALU inputs for the settle window, then respond.
    always_ff @(posedge clock or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            owner      <= 1'b0;
            cnt        <= '0;
            alu_a      <= '0;
            alu_b      <= '0;
            alu_cmd    <= '0;
            alu_oe     <= 1'b0;
            rsp0_valid <= 1'b0;
            rsp1_valid <= 1'b0;
            rsp0_data  <= '0;
            rsp1_data  <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (accept0) begin
                        alu_a      <= req0_a;
                        alu_b      <= req0_b;
                        alu_cmd    <= req0_cmd;
                        alu_oe     <= 1'b1;
                        cnt        <= CNT_LOAD;
                        owner      <= 1'b0;
                        last_grant <= 1'b0;
                        state      <= EXEC;
                    end else if (accept1) begin
                        alu_a      <= req1_a;
                        alu_b      <= req1_b;
                        alu_cmd    <= req1_cmd;
                        alu_oe     <= 1'b1;
                        cnt        <= CNT_LOAD;
                        owner      <= 1'b1;
                        last_grant <= 1'b1;
                        state      <= EXEC;
                    end
                end
                EXEC: begin
                    if (cnt == 4'd0) begin
                        if (owner) begin
                            rsp1_data  <= alu_d;
                            rsp1_valid <= 1'b1;
                        end else begin
                            rsp0_data  <= alu_d;
                            rsp0_valid <= 1'b1;
                        end
                        alu_oe <= 1'b0;
                        state  <= RESP;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    if (owner_rsp_ready) begin
                        rsp0_valid <= 1'b0;
                        rsp1_valid <= 1'b0;
                        state      <= IDLE;
                    end
                end
                default: begin
                    alu_oe     <= 1'b0;
                    rsp0_valid <= 1'b0;
                    rsp1_valid <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_alu_arbiter.sv
// tb_alu_arbiter: directed and randomized checks of alu_arbiter.
// Two instances: ua with EXEC_CYCLES=1, ub with EXEC_CYCLES=4. A behavioural
// ALU drives alu_d while alu_oe is high and a poison pattern otherwise.
module tb_alu_arbiter;

    logic clock = 1'b0;
    logic resetn;
    always #5 clock = ~clock;

    int unsigned vectors     = 0;
    int unsigned miscompares = 0;

    // Reference ALU: zero-extended 8-bit operands, 16-bit result.
    function automatic logic [15:0] alu_fn(input logic [7:0] a, input logic [7:0] b,
                                           input logic [3:0] c);
        case (c)
            4'd0:    return 16'(a) + 16'(b);
            4'd1:    return 16'(a) + 16'd1;
            4'd2:    return 16'(a) - 16'(b);
            4'd3:    return 16'(a) - 16'd1;
            4'd4:    return 16'(a) * 16'(b);
            4'd5:    return 16'(a & b);
            4'd6:    return 16'(a | b);
            4'd7:    return 16'(a ^ b);
            default: return 16'(a);
        endcase
    endfunction

    // ---------------- instance A (EXEC_CYCLES = 1) ----------------
    logic        a_req0_valid, a_req0_ready, a_rsp0_valid, a_rsp0_ready;
    logic [7:0]  a_req0_a, a_req0_b;
    logic [3:0]  a_req0_cmd;
    logic [15:0] a_rsp0_data;
    logic        a_req1_valid, a_req1_ready, a_rsp1_valid, a_rsp1_ready;
    logic [7:0]  a_req1_a, a_req1_b;
    logic [3:0]  a_req1_cmd;
    logic [15:0] a_rsp1_data;
    logic [7:0]  a_alu_a, a_alu_b;
    logic [3:0]  a_alu_cmd;
    logic        a_alu_oe, a_busy;
    logic [15:0] a_alu_d;

    assign a_alu_d = a_alu_oe ? alu_fn(a_alu_a, a_alu_b, a_alu_cmd) : 16'hDEAD;

    alu_arbiter #(.EXEC_CYCLES(1)) ua (
        .clock(clock), .resetn(resetn),
        .req0_valid(a_req0_valid), .req0_ready(a_req0_ready), .req0_a(a_req0_a),
        .req0_b(a_req0_b), .req0_cmd(a_req0_cmd), .rsp0_valid(a_rsp0_valid),
        .rsp0_ready(a_rsp0_ready), .rsp0_data(a_rsp0_data),
        .req1_valid(a_req1_valid), .req1_ready(a_req1_ready), .req1_a(a_req1_a),
        .req1_b(a_req1_b), .req1_cmd(a_req1_cmd), .rsp1_valid(a_rsp1_valid),
        .rsp1_ready(a_rsp1_ready), .rsp1_data(a_rsp1_data),
        .alu_a(a_alu_a), .alu_b(a_alu_b), .alu_cmd(a_alu_cmd), .alu_oe(a_alu_oe),
        .alu_d(a_alu_d), .busy(a_busy)
    );

    // ---------------- instance B (EXEC_CYCLES = 4) ----------------
    logic        b_req0_valid, b_req0_ready, b_rsp0_valid, b_rsp0_ready;
    logic [7:0]  b_req0_a, b_req0_b;
    logic [3:0]  b_req0_cmd;
    logic [15:0] b_rsp0_data;
    logic        b_req1_valid, b_req1_ready, b_rsp1_valid, b_rsp1_ready;
    logic [7:0]  b_req1_a, b_req1_b;
    logic [3:0]  b_req1_cmd;
    logic [15:0] b_rsp1_data;
    logic [7:0]  b_alu_a, b_alu_b;
    logic [3:0]  b_alu_cmd;
    logic        b_alu_oe, b_busy;
    logic [15:0] b_alu_d;

    assign b_alu_d = b_alu_oe ? alu_fn(b_alu_a, b_alu_b, b_alu_cmd) : 16'hDEAD;

    alu_arbiter #(.EXEC_CYCLES(4)) ub (
        .clock(clock), .resetn(resetn),
        .req0_valid(b_req0_valid), .req0_ready(b_req0_ready), .req0_a(b_req0_a),
        .req0_b(b_req0_b), .req0_cmd(b_req0_cmd), .rsp0_valid(b_rsp0_valid),
        .rsp0_ready(b_rsp0_ready), .rsp0_data(b_rsp0_data),
        .req1_valid(b_req1_valid), .req1_ready(b_req1_ready), .req1_a(b_req1_a),
        .req1_b(b_req1_b), .req1_cmd(b_req1_cmd), .rsp1_valid(b_rsp1_valid),
        .rsp1_ready(b_rsp1_ready), .rsp1_data(b_rsp1_data),
        .alu_a(b_alu_a), .alu_b(b_alu_b), .alu_cmd(b_alu_cmd), .alu_oe(b_alu_oe),
        .alu_d(b_alu_d), .busy(b_busy)
    );

    // ---------------- stimulus helpers ----------------
    task automatic idle_a();
        a_req0_valid = 1'b0; a_req0_a = '0; a_req0_b = '0; a_req0_cmd = '0;
        a_req1_valid = 1'b0; a_req1_a = '0; a_req1_b = '0; a_req1_cmd = '0;
        a_rsp0_ready = 1'b1; a_rsp1_ready = 1'b1;
    endtask

    task automatic idle_b();
        b_req0_valid = 1'b0; b_req0_a = '0; b_req0_b = '0; b_req0_cmd = '0;
        b_req1_valid = 1'b0; b_req1_a = '0; b_req1_b = '0; b_req1_cmd = '0;
        b_rsp0_ready = 1'b1; b_rsp1_ready = 1'b1;
    endtask

    task automatic do_reset();
        @(posedge clock); #1;
        resetn = 1'b0;
        repeat (2) @(posedge clock);
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // ---------------- tests ----------------
    task automatic test_reset();
        idle_a(); idle_b();
        resetn = 1'b0;
        #12;
        vectors++;
        if ({a_rsp0_valid, a_rsp1_valid, a_alu_oe, a_busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags_a: got %b expected 0000", {a_rsp0_valid, a_rsp1_valid, a_alu_oe, a_busy});
        end
        vectors++;
        if ({a_alu_a, a_alu_b, a_alu_cmd} !== 20'h0) begin
            miscompares++;
            $display("FAIL reset_alu_in_a: got %h expected 0", {a_alu_a, a_alu_b, a_alu_cmd});
        end
        vectors++;
        if ({a_rsp0_data, a_rsp1_data} !== 32'h0) begin
            miscompares++;
            $display("FAIL reset_rsp_data_a: got %h expected 0", {a_rsp0_data, a_rsp1_data});
        end
        vectors++;
        if ({b_rsp0_valid, b_rsp1_valid, b_alu_oe, b_busy} !== 4'b0000) begin
            miscompares++;
            $display("FAIL reset_flags_b: got %b expected 0000", {b_rsp0_valid, b_rsp1_valid, b_alu_oe, b_busy});
        end
        @(negedge clock);
        resetn = 1'b1;
    endtask

    // One transaction on instance A with response ready tied high.
    task automatic test_single(input bit r, input logic [7:0] a, input logic [7:0] b,
                               input logic [3:0] cmd, input logic [15:0] exp, input string name);
        logic rv, ov;
        @(posedge clock); #1;
        idle_a();
        if (r) begin a_req1_valid = 1'b1; a_req1_a = a; a_req1_b = b; a_req1_cmd = cmd; end
        else   begin a_req0_valid = 1'b1; a_req0_a = a; a_req0_b = b; a_req0_cmd = cmd; end
        @(negedge clock);
        vectors++;
        if ((r ? a_req1_ready : a_req0_ready) !== 1'b1 || (r ? a_req0_ready : a_req1_ready) !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_ready: got r0=%b r1=%b expected only req%0d", name, a_req0_ready, a_req1_ready, r);
        end
        @(posedge clock); #1;
        // Scramble request after the handshake; it must not leak into the result.
        a_req0_valid = 1'b0; a_req1_valid = 1'b0;
        a_req0_a = 8'($urandom); a_req1_a = 8'($urandom);
        a_req0_b = 8'($urandom); a_req1_b = 8'($urandom);
        @(negedge clock);
        rv = r ? a_rsp1_valid : a_rsp0_valid;
        vectors++;
        if (rv !== 1'b0 || a_busy !== 1'b1 || a_alu_oe !== 1'b1 || a_alu_a !== a) begin
            miscompares++;
            $display("FAIL %s_exec: got rsp_valid=%b busy=%b oe=%b alu_a=%h expected 0 1 1 %h", name, rv, a_busy, a_alu_oe, a_alu_a, a);
        end
        @(negedge clock);
        rv = r ? a_rsp1_valid : a_rsp0_valid;
        ov = r ? a_rsp0_valid : a_rsp1_valid;
        vectors++;
        if (rv !== 1'b1 || ov !== 1'b0 || (r ? a_rsp1_data : a_rsp0_data) !== exp) begin
            miscompares++;
            $display("FAIL %s_rsp: got valid=%b other=%b data=%h expected 1 0 %h", name, rv, ov, r ? a_rsp1_data : a_rsp0_data, exp);
        end
        @(negedge clock);
        vectors++;
        if (a_rsp0_valid !== 1'b0 || a_rsp1_valid !== 1'b0 || a_busy !== 1'b0 || a_alu_oe !== 1'b0) begin
            miscompares++;
            $display("FAIL %s_done: got v0=%b v1=%b busy=%b oe=%b expected 0 0 0 0", name, a_rsp0_valid, a_rsp1_valid, a_busy, a_alu_oe);
        end
    endtask

    // Both requesters valid continuously: grants must alternate starting with req0.
    task automatic test_back_to_back();
        int unsigned order[$];
        logic [16:0] resp[$];
        idle_a();
        do_reset();
        @(posedge clock); #1;
        a_req0_valid = 1'b1; a_req0_a = 8'h10; a_req0_b = 8'h00; a_req0_cmd = 4'd1;
        a_req1_valid = 1'b1; a_req1_a = 8'h10; a_req1_b = 8'h00; a_req1_cmd = 4'd3;
        for (int i = 0; i < 16; i++) begin
            @(negedge clock);
            if (a_req0_ready && a_req1_ready) begin
                vectors++; miscompares++;
                $display("FAIL b2b_two_readies: got both ready at step %0d expected at most one", i);
            end
            if (a_req0_ready) order.push_back(0);
            if (a_req1_ready) order.push_back(1);
            if (a_rsp0_valid) resp.push_back({1'b0, a_rsp0_data});
            if (a_rsp1_valid) resp.push_back({1'b1, a_rsp1_data});
        end
        idle_a();
        vectors++;
        if (order.size() < 4 || resp.size() < 4) begin
            miscompares++;
            $display("FAIL b2b_count: got accepts=%0d responses=%0d expected at least 4 each", order.size(), resp.size());
        end else begin
            for (int k = 0; k < 4; k++) begin
                logic [16:0] want;
                want = (k % 2 == 0) ? {1'b0, 16'h0011} : {1'b1, 16'h000F};
                vectors++;
                if (order[k] != int'(k % 2)) begin
                    miscompares++;
                    $display("FAIL b2b_order[%0d]: got req%0d expected req%0d", k, order[k], k % 2);
                end
                vectors++;
                if (resp[k] !== want) begin
                    miscompares++;
                    $display("FAIL b2b_resp[%0d]: got %h expected %h", k, resp[k], want);
                end
            end
        end
        repeat (3) @(negedge clock);
    endtask

    // Response back-pressure stalls the arbiter; waiting requester gets the next slot.
    task automatic test_backpressure();
        @(posedge clock); #1;
        idle_a();
        a_rsp0_ready = 1'b0;
        a_req0_valid = 1'b1; a_req0_a = 8'h12; a_req0_b = 8'h34; a_req0_cmd = 4'd0;
        @(negedge clock);
        vectors++;
        if (a_req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_accept0: got %b expected 1", a_req0_ready);
        end
        @(posedge clock); #1;
        a_req0_valid = 1'b0;
        a_req1_valid = 1'b1; a_req1_a = 8'h05; a_req1_b = 8'h03; a_req1_cmd = 4'd2;
        @(negedge clock);
        @(negedge clock);
        for (int i = 0; i < 6; i++) begin
            vectors++;
            if (a_rsp0_valid !== 1'b1 || a_rsp0_data !== 16'h0046 || a_req1_ready !== 1'b0) begin
                miscompares++;
                $display("FAIL bp_hold[%0d]: got v=%b d=%h r1=%b expected 1 0046 0", i, a_rsp0_valid, a_rsp0_data, a_req1_ready);
            end
            if (i < 5) @(negedge clock);
        end
        @(posedge clock); #1;
        a_rsp0_ready = 1'b1;
        @(negedge clock);
        vectors++;
        if (a_req1_ready !== 1'b0 || a_rsp0_valid !== 1'b1) begin
            miscompares++;
            $display("FAIL bp_release: got r1=%b v0=%b expected 0 1", a_req1_ready, a_rsp0_valid);
        end
        @(negedge clock);
        vectors++;
        if (a_req1_ready !== 1'b1 || a_rsp0_valid !== 1'b0) begin
            miscompares++;
            $display("FAIL bp_next_accept: got r1=%b v0=%b expected 1 0", a_req1_ready, a_rsp0_valid);
        end
        @(posedge clock); #1;
        a_req1_valid = 1'b0;
        @(negedge clock);
        @(negedge clock);
        vectors++;
        if (a_rsp1_valid !== 1'b1 || a_rsp1_data !== 16'h0002 || a_rsp0_data !== 16'h0046) begin
            miscompares++;
            $display("FAIL bp_rsp1: got v1=%b d1=%h d0=%h expected 1 0002 0046", a_rsp1_valid, a_rsp1_data, a_rsp0_data);
        end
        repeat (2) @(negedge clock);
    endtask

    // Longer settle window on instance B.
    task automatic test_exec4();
        int unsigned oe_cnt;
        int          first_valid;
        oe_cnt = 0;
        first_valid = -1;
        @(posedge clock); #1;
        idle_b();
        b_req0_valid = 1'b1; b_req0_a = 8'hF0; b_req0_b = 8'hFF; b_req0_cmd = 4'd7;
        @(negedge clock);
        vectors++;
        if (b_req0_ready !== 1'b1) begin
            miscompares++;
            $display("FAIL e4_accept: got %b expected 1", b_req0_ready);
        end
        @(posedge clock); #1;
        b_req0_valid = 1'b0;
        for (int k = 0; k < 8; k++) begin
            @(negedge clock);
            if (b_alu_oe === 1'b1) oe_cnt++;
            if (b_rsp0_valid === 1'b1 && first_valid < 0) first_valid = k;
            if (k == 4) begin
                vectors++;
                if (b_rsp0_data !== 16'h000F) begin
                    miscompares++;
                    $display("FAIL e4_data: got %h expected 000f", b_rsp0_data);
                end
            end
        end
        vectors++;
        if (oe_cnt != 4) begin
            miscompares++;
            $display("FAIL e4_oe_cycles: got %0d expected 4", oe_cnt);
        end
        vectors++;
        if (first_valid != 4) begin
            miscompares++;
            $display("FAIL e4_latency: got %0d expected 4", first_valid);
        end
    endtask

    // Reset mid-EXEC drops the operation and restores the round-robin pointer.
    task automatic test_reset_mid();
        @(posedge clock); #1;
        idle_b();
        b_req0_valid = 1'b1; b_req0_a = 8'h01; b_req0_b = 8'h01; b_req0_cmd = 4'd0;
        @(posedge clock); #1;
        b_req0_valid = 1'b0;
        @(negedge clock);
        vectors++;
        if (b_alu_oe !== 1'b1 || b_busy !== 1'b1) begin
            miscompares++;
            $display("FAIL rm_exec: got oe=%b busy=%b expected 1 1", b_alu_oe, b_busy);
        end
        #1 resetn = 1'b0;
        #1;
        vectors++;
        if ({b_alu_oe, b_busy, b_rsp0_valid, b_rsp1_valid} !== 4'b0000) begin
            miscompares++;
            $display("FAIL rm_async: got %b expected 0000", {b_alu_oe, b_busy, b_rsp0_valid, b_rsp1_valid});
        end
        @(posedge clock); #2;
        resetn = 1'b1;
        for (int i = 0; i < 6; i++) begin
            @(negedge clock);
            vectors++;
            if (b_rsp0_valid !== 1'b0 || b_busy !== 1'b0) begin
                miscompares++;
                $display("FAIL rm_no_rsp[%0d]: got v0=%b busy=%b expected 0 0", i, b_rsp0_valid, b_busy);
            end
        end
        @(posedge clock); #1;
        b_req0_valid = 1'b1; b_req1_valid = 1'b1;
        @(negedge clock);
        vectors++;
        if (b_req0_ready !== 1'b1 || b_req1_ready !== 1'b0) begin
            miscompares++;
            $display("FAIL rm_tie: got r0=%b r1=%b expected 1 0", b_req0_ready, b_req1_ready);
        end
        @(posedge clock); #1;
        idle_b();
        repeat (8) @(negedge clock);
    endtask

    // Random traffic on instance A against a transaction-level timing model.
    task automatic test_random();
        localparam int unsigned E = 1;
        bit          pend, own, lg;
        int unsigned rem;
        logic [15:0] res, last0, last1;
        bit          g0, g1;
        idle_a();
        do_reset();
        pend = 0; own = 0; lg = 1; rem = 0; res = '0; last0 = '0; last1 = '0;
        for (int n = 0; n < 400; n++) begin
            @(posedge clock); #1;
            a_req0_valid = 1'($urandom_range(0, 1)); a_req1_valid = 1'($urandom_range(0, 1));
            a_req0_a = 8'($urandom); a_req0_b = 8'($urandom); a_req0_cmd = 4'($urandom_range(0, 7));
            a_req1_a = 8'($urandom); a_req1_b = 8'($urandom); a_req1_cmd = 4'($urandom_range(0, 7));
            a_rsp0_ready = ($urandom_range(0, 9) < 7); a_rsp1_ready = ($urandom_range(0, 9) < 7);
            @(negedge clock);
            g0 = !pend && a_req0_valid && (!a_req1_valid || lg);
            g1 = !pend && a_req1_valid && (!a_req0_valid || !lg);
            vectors++;
            if (a_req0_ready !== g0 || a_req1_ready !== g1) begin
                miscompares++;
                $display("FAIL rnd_ready[%0d]: got %b%b expected %b%b", n, a_req0_ready, a_req1_ready, g0, g1);
            end
            vectors++;
            if (a_rsp0_valid !== (pend && rem == 0 && !own) || a_rsp1_valid !== (pend && rem == 0 && own)) begin
                miscompares++;
                $display("FAIL rnd_rsp_valid[%0d]: got %b%b expected %b%b", n, a_rsp0_valid, a_rsp1_valid,
                         pend && rem == 0 && !own, pend && rem == 0 && own);
            end
            vectors++;
            if (a_rsp0_data !== last0 || a_rsp1_data !== last1) begin
                miscompares++;
                $display("FAIL rnd_data[%0d]: got %h %h expected %h %h", n, a_rsp0_data, a_rsp1_data, last0, last1);
            end
            vectors++;
            if (a_busy !== pend || a_alu_oe !== (pend && rem > 0)) begin
                miscompares++;
                $display("FAIL rnd_busy_oe[%0d]: got %b %b expected %b %b", n, a_busy, a_alu_oe, pend, pend && rem > 0);
            end
            if (pend) begin
                if (rem == 0) begin
                    if (own ? a_rsp1_ready : a_rsp0_ready) pend = 0;
                end else begin
                    rem--;
                    if (rem == 0) begin
                        if (own) last1 = res; else last0 = res;
                    end
                end
            end else if (g0) begin
                pend = 1; own = 0; lg = 0; rem = E;
                res = alu_fn(a_req0_a, a_req0_b, a_req0_cmd);
            end else if (g1) begin
                pend = 1; own = 1; lg = 1; rem = E;
                res = alu_fn(a_req1_a, a_req1_b, a_req1_cmd);
            end
        end
        @(posedge clock); #1;
        idle_a();
        repeat (4) @(negedge clock);
    endtask

    initial begin
        test_reset();
        test_single(1'b0, 8'h0F, 8'h01, 4'd0, 16'h0010, "add0");
        test_single(1'b1, 8'hFF, 8'hFF, 4'd4, 16'hFE01, "mul1");
        test_single(1'b1, 8'h00, 8'h01, 4'd2, 16'hFFFF, "sub1");
        test_back_to_back();
        test_backpressure();
        test_exec4();
        test_reset_mid();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
